// File: rtl/axi4_lite_route_decoder_if.sv
// Bus bundle for axi4_lite_route_decoder: master-side AXI4-Lite control, routing outputs, error slave.
// AXIL_ROUTE_DECERR_CNT_EN adds the DECERR counters.
interface axi4_lite_route_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLAVE_NUM  = 2
);
  localparam int unsigned IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  w_valid;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  r_valid;
  logic                  r_ready;

  logic                  wr_route_valid;
  logic [SLAVE_NUM-1:0]  wr_sel;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_err;
  logic                  rd_route_valid;
  logic [SLAVE_NUM-1:0]  rd_sel;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_err;

  logic                  err_awready;
  logic                  err_wready;
  logic                  err_bvalid;
  logic [1:0]            err_bresp;
  logic                  err_arready;
  logic                  err_rvalid;
  logic [DATA_WIDTH-1:0] err_rdata;
  logic [1:0]            err_rresp;
`ifdef AXIL_ROUTE_DECERR_CNT_EN
  logic [15:0]           wr_decerr_cnt;
  logic [15:0]           rd_decerr_cnt;
`endif

  modport master (
    output aw_addr, aw_valid, w_valid, b_valid, b_ready,
           ar_addr, ar_valid, r_valid, r_ready,
    input  wr_route_valid, wr_sel, wr_idx, wr_err,
           rd_route_valid, rd_sel, rd_idx, rd_err,
           err_awready, err_wready, err_bvalid, err_bresp,
           err_arready, err_rvalid, err_rdata, err_rresp
`ifdef AXIL_ROUTE_DECERR_CNT_EN
    , input wr_decerr_cnt, rd_decerr_cnt
`endif
  );

  modport slave (
    input  aw_addr, aw_valid, w_valid, b_valid, b_ready,
           ar_addr, ar_valid, r_valid, r_ready,
    output wr_route_valid, wr_sel, wr_idx, wr_err,
           rd_route_valid, rd_sel, rd_idx, rd_err,
           err_awready, err_wready, err_bvalid, err_bresp,
           err_arready, err_rvalid, err_rdata, err_rresp
`ifdef AXIL_ROUTE_DECERR_CNT_EN
    , output wr_decerr_cnt, rd_decerr_cnt
`endif
  );
endinterface

// File: rtl/axi4_lite_route_decoder.sv
// Registered AXI4-Lite write/read address decoder with a built-in DECERR error slave.
// Optional macro AXIL_ROUTE_DECERR_CNT_EN adds saturating per-direction DECERR counters.
module axi4_lite_route_decoder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLAVE_NUM  = 2,
  parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = {32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input logic clk,
  input logic rst_n,
  axi4_lite_route_decoder_if.slave bus
);
  localparam int unsigned IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  typedef enum logic [2:0] {W_IDLE, W_ROUTE, W_ERR_ADDR, W_ERR_DATA, W_ERR_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ROUTE, R_ERR_ADDR, R_ERR_RESP} r_state_e;
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Ascending scan with a hit guard gives lowest-index priority.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
    dec_t d;
    d = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (!d.hit && ((addr & SLAVE_ADDR_MASK[i]) == SLAVE_BASE_ADDR[i])) begin
        d.hit = 1'b1;
        d.idx = IDX_W'(i);
      end
    end
    return d;
  endfunction

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic [SLAVE_NUM-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  dec_t                 w_dec, r_dec;
  logic                 w_err_entry, r_err_entry;

  assign w_dec = decode(bus.aw_addr);
  assign r_dec = decode(bus.ar_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wr_sel_q  <= '0;
      wr_idx_q  <= '0;
      rd_sel_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_sel_q  <= wr_sel_d;
      wr_idx_q  <= wr_idx_d;
      rd_sel_q  <= rd_sel_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_comb begin
    w_state_d   = w_state_q;
    wr_sel_d    = wr_sel_q;
    wr_idx_d    = wr_idx_q;
    w_err_entry = 1'b0;
    case (w_state_q)
      W_IDLE: if (bus.aw_valid) begin
        if (w_dec.hit) begin
          w_state_d = W_ROUTE;
          wr_sel_d  = SLAVE_NUM'(1) << w_dec.idx;
          wr_idx_d  = w_dec.idx;
        end else begin
          w_state_d   = W_ERR_ADDR;
          w_err_entry = 1'b1;
        end
      end
      W_ROUTE: if (bus.b_valid && bus.b_ready) begin
        w_state_d = W_IDLE;
        wr_sel_d  = '0;
        wr_idx_d  = '0;
      end
      W_ERR_ADDR: if (bus.aw_valid) w_state_d = W_ERR_DATA;
      W_ERR_DATA: if (bus.w_valid)  w_state_d = W_ERR_RESP;
      W_ERR_RESP: if (bus.b_ready)  w_state_d = W_IDLE;
      default:    w_state_d = W_IDLE;
    endcase

    bus.wr_route_valid = (w_state_q != W_IDLE);
    bus.wr_sel         = wr_sel_q;
    bus.wr_idx         = wr_idx_q;
    bus.wr_err         = (w_state_q == W_ERR_ADDR) || (w_state_q == W_ERR_DATA) ||
                         (w_state_q == W_ERR_RESP);
    bus.err_awready    = (w_state_q == W_ERR_ADDR) && bus.aw_valid;
    bus.err_wready     = (w_state_q == W_ERR_DATA) && bus.w_valid;
    bus.err_bvalid     = (w_state_q == W_ERR_RESP);
    bus.err_bresp      = (w_state_q == W_ERR_RESP) ? 2'b11 : 2'b00;
  end

  always_comb begin
    r_state_d   = r_state_q;
    rd_sel_d    = rd_sel_q;
    rd_idx_d    = rd_idx_q;
    r_err_entry = 1'b0;
    case (r_state_q)
      R_IDLE: if (bus.ar_valid) begin
        if (r_dec.hit) begin
          r_state_d = R_ROUTE;
          rd_sel_d  = SLAVE_NUM'(1) << r_dec.idx;
          rd_idx_d  = r_dec.idx;
        end else begin
          r_state_d   = R_ERR_ADDR;
          r_err_entry = 1'b1;
        end
      end
      R_ROUTE: if (bus.r_valid && bus.r_ready) begin
        r_state_d = R_IDLE;
        rd_sel_d  = '0;
        rd_idx_d  = '0;
      end
      R_ERR_ADDR: if (bus.ar_valid) r_state_d = R_ERR_RESP;
      R_ERR_RESP: if (bus.r_ready)  r_state_d = R_IDLE;
      default:    r_state_d = R_IDLE;
    endcase

    bus.rd_route_valid = (r_state_q != R_IDLE);
    bus.rd_sel         = rd_sel_q;
    bus.rd_idx         = rd_idx_q;
    bus.rd_err         = (r_state_q == R_ERR_ADDR) || (r_state_q == R_ERR_RESP);
    bus.err_arready    = (r_state_q == R_ERR_ADDR) && bus.ar_valid;
    bus.err_rvalid     = (r_state_q == R_ERR_RESP);
    bus.err_rresp      = (r_state_q == R_ERR_RESP) ? 2'b11 : 2'b00;
    bus.err_rdata      = (r_state_q == R_ERR_RESP) ? ERR_RDATA : '0;
  end

`ifdef AXIL_ROUTE_DECERR_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (w_err_entry && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    if (r_err_entry && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.wr_decerr_cnt = wr_cnt_q;
  assign bus.rd_decerr_cnt = rd_cnt_q;
`else
  // Error-entry strobes only feed the optional counters.
  logic unused_err_entry;
  assign unused_err_entry = w_err_entry ^ r_err_entry;
`endif

endmodule
